// File: rtl/core_run_ctrl_if.sv
// Run-control bus between the host/debug side (master) and the sequencer (slave).
// Carries halt/resume requests, the breakpoint compare inputs and the core enable status.
interface core_run_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             resume;
  logic             host_halt;
  logic             sys_halt;
  logic             step_mode;
  logic [CNT_W-1:0] burst_len;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic             en;
  logic             halted;
  logic [2:0]       halt_cause;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output resume, host_halt, sys_halt, step_mode, burst_len, bp_en, bp_addr, pc,
    input  en, halted, halt_cause, cycle_cnt
  );

  modport slave (
    input  resume, host_halt, sys_halt, step_mode, burst_len, bp_en, bp_addr, pc,
    output en, halted, halt_cause, cycle_cnt
  );
endinterface

// File: rtl/core_run_ctrl.sv
// Run-control sequencer: owns the core-wide clock enable, halts on syscall/breakpoint/host,
// resumes free-running, single-step or N-cycle burst, and counts enabled cycles.
module core_run_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  core_run_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_STEP   = 2'd1,
    S_BURST  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] CAUSE_RUN  = 3'd0;
  localparam logic [2:0] CAUSE_SYS  = 3'd1;
  localparam logic [2:0] CAUSE_BP   = 3'd2;
  localparam logic [2:0] CAUSE_HOST = 3'd3;
  localparam logic [2:0] CAUSE_DONE = 3'd4;

  state_t           r_state;
  logic             r_en;
  logic [2:0]       r_cause;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_resume_q;
  logic             r_bp_skip;

  logic w_rise;
  logic w_bp_hit;
  logic w_run_done;

  assign w_rise     = bus.resume & ~r_resume_q;
  assign w_bp_hit   = bus.bp_en & (bus.pc == bus.bp_addr) & ~r_bp_skip;
  // Step always ends after its single cycle; a burst ends on the cycle its counter reads 1.
  assign w_run_done = (r_state == S_STEP) || ((r_state == S_BURST) && (r_burst_cnt == CNT_ONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_en        <= 1'b1;
      r_cause     <= CAUSE_RUN;
      r_cycle_cnt <= '0;
      r_burst_cnt <= '0;
      r_resume_q  <= 1'b0;
      r_bp_skip   <= 1'b0;
    end else begin
      r_resume_q <= bus.resume;
      if (r_en) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
        r_bp_skip   <= 1'b0;
        if (r_state == S_BURST) r_burst_cnt <= r_burst_cnt - CNT_ONE;
        if (bus.sys_halt) begin
          r_state <= S_HALTED;
          r_en    <= 1'b0;
          r_cause <= CAUSE_SYS;
        end else if (w_bp_hit) begin
          r_state <= S_HALTED;
          r_en    <= 1'b0;
          r_cause <= CAUSE_BP;
        end else if (bus.host_halt) begin
          r_state <= S_HALTED;
          r_en    <= 1'b0;
          r_cause <= CAUSE_HOST;
        end else if (w_run_done) begin
          r_state <= S_HALTED;
          r_en    <= 1'b0;
          r_cause <= CAUSE_DONE;
        end
      end else if (w_rise) begin
        // bp_skip lets the instruction sitting on the breakpoint execute once.
        r_en      <= 1'b1;
        r_cause   <= CAUSE_RUN;
        r_bp_skip <= 1'b1;
        if (bus.step_mode) begin
          r_state <= S_STEP;
        end else if (bus.burst_len != '0) begin
          r_state     <= S_BURST;
          r_burst_cnt <= bus.burst_len;
        end else begin
          r_state <= S_RUN;
        end
      end
    end
  end

  assign bus.en         = r_en;
  assign bus.halted     = ~r_en;
  assign bus.halt_cause = r_cause;
  assign bus.cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: directed scenarios then random traffic,
// checked against a cycles-remaining reference model.
module tb_core_run_ctrl;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam logic [PC_W-1:0] BP = 32'h0040_0010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  core_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic             en;
    logic             halted;
    logic [2:0]       cause;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: running flag plus "enabled cycles left" (-1 = unlimited).
  bit m_run;
  int m_left;
  int m_cause;
  int m_cnt;
  bit m_prev_res;
  bit m_skip;

  task automatic model_edge();
    bit rise;
    bit hit;
    int c;
    if (rst) begin
      m_run = 1; m_left = -1; m_cause = 0; m_cnt = 0; m_prev_res = 0; m_skip = 0;
    end else begin
      rise = bus.resume && !m_prev_res;
      m_prev_res = bus.resume;
      if (m_run) begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        hit = bus.bp_en && (bus.pc == bus.bp_addr) && !m_skip;
        m_skip = 0;
        c = 0;
        if (bus.sys_halt)       c = 1;
        else if (hit)           c = 2;
        else if (bus.host_halt) c = 3;
        else if (m_left == 1)   c = 4;
        if (m_left > 0) m_left = m_left - 1;
        if (c != 0) begin
          m_run = 0;
          m_cause = c;
        end
      end else if (rise) begin
        m_run = 1;
        m_cause = 0;
        m_skip = 1;
        if (bus.step_mode)            m_left = 1;
        else if (bus.burst_len != 0)  m_left = int'(bus.burst_len);
        else                          m_left = -1;
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    model_edge();
    e.en     = m_run;
    e.halted = !m_run;
    e.cause  = 3'(m_cause);
    e.cnt    = CNT_W'(m_cnt);
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle, so pop one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("en",         32'(bus.en),         32'(e.en));
        check("halted",     32'(bus.halted),     32'(e.halted));
        check("halt_cause", 32'(bus.halt_cause), 32'(e.cause));
        check("cycle_cnt",  32'(bus.cycle_cnt),  32'(e.cnt));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    rst = 1'b1;
    bus.resume = 0; bus.host_halt = 0; bus.sys_halt = 0; bus.step_mode = 0;
    bus.burst_len = '0; bus.bp_en = 0; bus.bp_addr = BP; bus.pc = '0;

    ticks(2);
    rst = 1'b0;
    ticks(3);

    // Syscall halt at cycle_cnt=5, then a held resume gives one resume only.
    guard = 0;
    while (m_cnt != 5 && guard < 40) begin tick(); guard++; end
    bus.sys_halt = 1; tick(); bus.sys_halt = 0;
    ticks(3);
    bus.resume = 1; ticks(4); bus.resume = 0;
    ticks(2);

    // Host halt, then three single steps.
    bus.host_halt = 1; tick(); bus.host_halt = 0;
    bus.step_mode = 1;
    for (int i = 0; i < 3; i++) begin
      bus.resume = 1; tick(); bus.resume = 0; ticks(3);
    end
    bus.step_mode = 0;

    // Burst of 3, then a burst cut short by sys_halt in its 2nd cycle.
    bus.burst_len = 3;
    bus.resume = 1; tick(); bus.resume = 0; ticks(5);
    bus.resume = 1; tick(); bus.resume = 0; tick();
    bus.sys_halt = 1; tick(); bus.sys_halt = 0; ticks(3);
    bus.burst_len = '0;

    // Breakpoint with pc parked on it: halt, resume past it once, halt again.
    bus.resume = 1; tick(); bus.resume = 0; ticks(2);
    bus.bp_en = 1; bus.pc = BP; ticks(3);
    bus.resume = 1; tick(); bus.resume = 0; ticks(4);
    bus.bp_en = 0; bus.pc = '0;

    // Simultaneous sys_halt and host_halt, resume against a held host_halt.
    bus.resume = 1; tick(); bus.resume = 0; ticks(2);
    bus.sys_halt = 1; bus.host_halt = 1; tick(); bus.sys_halt = 0; ticks(2);
    bus.resume = 1; tick(); bus.resume = 0; ticks(2);
    bus.host_halt = 0;

    // Reset in the middle of a burst.
    bus.resume = 1; tick(); bus.resume = 0;
    bus.burst_len = 5; ticks(2);
    bus.host_halt = 1; tick(); bus.host_halt = 0;
    bus.resume = 1; tick(); bus.resume = 0; ticks(2);
    rst = 1; tick(); rst = 0; ticks(20);
    bus.burst_len = '0;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.resume    = ($urandom_range(0, 3) == 0);
      bus.host_halt = ($urandom_range(0, 14) == 0);
      bus.sys_halt  = ($urandom_range(0, 14) == 0);
      bus.step_mode = ($urandom_range(0, 3) == 0);
      bus.burst_len = CNT_W'($urandom_range(0, 5));
      bus.bp_en     = ($urandom_range(0, 1) == 1);
      bus.pc        = ($urandom_range(0, 3) == 0) ? BP : PC_W'($urandom);
      tick();
    end
    rst = 0; bus.resume = 0; bus.host_halt = 0; bus.sys_halt = 0; bus.bp_en = 0;
    ticks(2);

    @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
